hls_deadlock_report_arbiter: RTL and testbench

HLS_DEADLOCK_REPORT_ARBITER -- requirements
Module: hls_deadlock_report_arbiter

---
 rtl/hls_deadlock_report_arbiter.sv | 169 ++++++++++++++++
 tb/tb_hls_deadlock_report_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_deadlock_report_arbiter.sv
// Confirms sustained deadlock-monitor block flags and reports each one once, round-robin, over a valid/ready port.
// Optional build macro HLS_DEADLOCK_RPT_STAMP_EN adds a 32-bit cycle stamp to each report; otherwise rpt_stamp is tied to 0.
module hls_deadlock_report_arbiter #(
    parameter int N_MON       = 4,
    parameter int CONFIRM_CYC = 16,
    parameter int IDX_W       = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_MON-1:0] mon_block,
    input  logic             clear,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [IDX_W-1:0] rpt_idx,
    output logic [31:0]      rpt_stamp,
    output logic [N_MON-1:0] sticky,
    output logic             any_block
);
    typedef enum logic {
        IDLE   = 1'b0,
        REPORT = 1'b1
    } state_t;

    localparam logic [7:0] CONFIRM = 8'(CONFIRM_CYC);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   rr_ptr_reg;
    logic [IDX_W-1:0]   rpt_idx_reg;
    logic               any_block_reg;
    logic [N_MON-1:0]   pending;
    logic [N_MON-1:0]   armed;
    logic [2*N_MON-1:0] pend_dbl;
    logic [N_MON-1:0]   pend_rot;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_found;
    logic               grant;
    logic               handshake;

    assign rpt_valid = (state_reg == REPORT);
    assign handshake = rpt_valid && rpt_ready;
    assign rpt_idx   = rpt_idx_reg;
    assign any_block = any_block_reg;

    generate
        for (genvar gi = 0; gi < N_MON; gi++) begin : g_chan
            logic [7:0] cnt_reg;
            logic       pending_reg;
            logic       armed_reg;
            logic       sticky_reg;
            logic       reach;
            logic       is_rpt;

            // Fires only on the edge the counter arrives at the threshold, so a held block confirms once.
            assign reach  = mon_block[gi] && !clear && (cnt_reg == CONFIRM - 8'd1);
            assign is_rpt = (rpt_idx_reg == IDX_W'(gi));

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    cnt_reg     <= '0;
                    pending_reg <= 1'b0;
                    armed_reg   <= 1'b1;
                    sticky_reg  <= 1'b0;
                end else begin
                    // clear restarts confirmation so a still-held block re-reports after a full window
                    if (!mon_block[gi] || clear)
                        cnt_reg <= '0;
                    else if (cnt_reg != CONFIRM)
                        cnt_reg <= cnt_reg + 8'd1;

                    if (!mon_block[gi])
                        pending_reg <= 1'b0;
                    else if (grant && grant_idx == IDX_W'(gi))
                        pending_reg <= 1'b0;
                    else if (reach && armed_reg)
                        pending_reg <= 1'b1;

                    if (clear || !mon_block[gi])
                        armed_reg <= 1'b1;
                    else if (handshake && is_rpt)
                        armed_reg <= 1'b0;

                    if (clear)
                        sticky_reg <= 1'b0;
                    else if (handshake && is_rpt)
                        sticky_reg <= 1'b1;
                end
            end

            assign pending[gi] = pending_reg;
            assign armed[gi]   = armed_reg;
            assign sticky[gi]  = sticky_reg;
        end
    endgenerate

    // Rotate pending so bit 0 lines up with rr_ptr; the first set bit is the grant.
    assign pend_dbl = {pending, pending};
    assign pend_rot = N_MON'(pend_dbl >> rr_ptr_reg);

    always_comb begin
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 0; k < N_MON; k++) begin
            if (!grant_found && pend_rot[k]) begin
                grant_found = 1'b1;
                cand        = int'(rr_ptr_reg) + k;
                if (cand >= N_MON)
                    cand = cand - N_MON;
                grant_idx = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        grant      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    state_next = REPORT;
                    grant      = 1'b1;
                end
            end
            REPORT: begin
                if (rpt_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            rpt_idx_reg   <= '0;
            any_block_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            any_block_reg <= |mon_block;
            if (grant)
                rpt_idx_reg <= grant_idx;
            if (handshake)
                rr_ptr_reg <= (rpt_idx_reg == IDX_W'(N_MON - 1)) ? '0 : rpt_idx_reg + IDX_W'(1);
        end
    end

`ifdef HLS_DEADLOCK_RPT_STAMP_EN
    logic [31:0] stamp_cnt_reg;
    logic [31:0] rpt_stamp_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stamp_cnt_reg <= '0;
            rpt_stamp_reg <= '0;
        end else begin
            stamp_cnt_reg <= stamp_cnt_reg + 32'd1;
            if (grant)
                rpt_stamp_reg <= stamp_cnt_reg;
        end
    end

    assign rpt_stamp = rpt_stamp_reg;
`else
    assign rpt_stamp = 32'd0;
`endif

endmodule

// File: tb/tb_hls_deadlock_report_arbiter.sv
// Self-checking bench: directed sequences, a vector table and a long random run against a behavioural model.
module tb_hls_deadlock_report_arbiter;
    localparam int N = 4;
    localparam int C = 16;
`ifdef HLS_DEADLOCK_RPT_STAMP_EN
    localparam bit STAMP_EN = 1'b1;
`else
    localparam bit STAMP_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  mon_block;
    logic        clear;
    logic        rpt_valid;
    logic        rpt_ready;
    logic [1:0]  rpt_idx;
    logic [31:0] rpt_stamp;
    logic [3:0]  sticky;
    logic        any_block;

    always #5 clock = ~clock;

    hls_deadlock_report_arbiter #(
        .N_MON      (N),
        .CONFIRM_CYC(C),
        .IDX_W      (2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .mon_block(mon_block),
        .clear    (clear),
        .rpt_valid(rpt_valid),
        .rpt_ready(rpt_ready),
        .rpt_idx  (rpt_idx),
        .rpt_stamp(rpt_stamp),
        .sticky   (sticky),
        .any_block(any_block)
    );

    int checks   = 0;
    int failures = 0;
    int txn_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: run lengths of each block flag plus report bookkeeping.
    int          run_len [N];
    bit          m_armed [N];
    bit          m_pend  [N];
    bit [3:0]    m_sticky;
    bit          m_valid;
    int          m_idx;
    int          m_rr;
    bit [31:0]   m_cyc;
    bit [31:0]   m_stamp;
    bit          m_any;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            run_len[i] = 0;
            m_armed[i] = 1'b1;
            m_pend[i]  = 1'b0;
        end
        m_sticky = '0;
        m_valid  = 1'b0;
        m_idx    = 0;
        m_rr     = 0;
        m_cyc    = '0;
        m_stamp  = '0;
        m_any    = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] mb, input logic clr, input logic rdy);
        bit hs;
        int g;
        int old;
        bit reach;
        hs = m_valid && rdy;
        g  = -1;
        if (!m_valid) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && m_pend[(m_rr + k) % N])
                    g = (m_rr + k) % N;
            end
        end
        for (int i = 0; i < N; i++) begin
            old = run_len[i];
            if (clr || !mb[i])
                run_len[i] = 0;
            else if (old < C)
                run_len[i] = old + 1;
            reach = (run_len[i] == C) && (old != C);
            if (!mb[i])
                m_pend[i] = 1'b0;
            else if (g == i)
                m_pend[i] = 1'b0;
            else if (reach && m_armed[i])
                m_pend[i] = 1'b1;
            if (clr || !mb[i])
                m_armed[i] = 1'b1;
            else if (hs && m_idx == i)
                m_armed[i] = 1'b0;
        end
        if (clr)
            m_sticky = '0;
        else if (hs)
            m_sticky[m_idx] = 1'b1;
        if (hs) begin
            txn_cnt++;
            $display("txn %0d: idx=%0d stamp=%0d", txn_cnt, m_idx, m_stamp);
            m_rr = (m_idx + 1) % N;
        end
        if (m_valid) begin
            if (hs)
                m_valid = 1'b0;
        end else if (g >= 0) begin
            m_valid = 1'b1;
            m_idx   = g;
            m_stamp = STAMP_EN ? m_cyc : 32'd0;
        end
        m_cyc = m_cyc + 32'd1;
        m_any = |mb;
    endtask

    task automatic tick();
        model_edge(mon_block, clear, rpt_ready);
        @(posedge clock);
        #1;
        check("m_valid", 32'(rpt_valid), 32'(m_valid));
        check("m_sticky", 32'(sticky), 32'(m_sticky));
        check("m_any_block", 32'(any_block), 32'(m_any));
        if (m_valid) begin
            check("m_idx", 32'(rpt_idx), 32'(m_idx));
            check("m_stamp", rpt_stamp, m_stamp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        mon_block = '0;
        clear     = 1'b0;
        rpt_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    typedef struct {
        logic [3:0] mb;
        logic       clr;
        logic       rdy;
        int         n;
        logic       exp_valid;
        logic [1:0] exp_idx;
        logic [3:0] exp_sticky;
    } vec_t;

    initial begin
        vec_t vecs [11];
        int   seen;
        logic [31:0] held_stamp;
        vecs[0]  = '{4'b1010, 1'b0, 1'b1, 16, 1'b0, 2'd0, 4'b0000};
        vecs[1]  = '{4'b1010, 1'b0, 1'b1,  1, 1'b1, 2'd1, 4'b0000};
        vecs[2]  = '{4'b1010, 1'b0, 1'b1,  1, 1'b0, 2'd0, 4'b0010};
        vecs[3]  = '{4'b1010, 1'b0, 1'b1,  1, 1'b1, 2'd3, 4'b0010};
        vecs[4]  = '{4'b1010, 1'b0, 1'b1,  1, 1'b0, 2'd0, 4'b1010};
        vecs[5]  = '{4'b1010, 1'b0, 1'b1, 20, 1'b0, 2'd0, 4'b1010};
        vecs[6]  = '{4'b1010, 1'b1, 1'b1,  1, 1'b0, 2'd0, 4'b0000};
        vecs[7]  = '{4'b1010, 1'b0, 1'b1, 16, 1'b0, 2'd0, 4'b0000};
        vecs[8]  = '{4'b1010, 1'b0, 1'b1,  1, 1'b1, 2'd1, 4'b0000};
        vecs[9]  = '{4'b1010, 1'b0, 1'b1,  1, 1'b0, 2'd0, 4'b0010};
        vecs[10] = '{4'b1010, 1'b0, 1'b1,  1, 1'b1, 2'd3, 4'b0010};

        // Reset values, before any active edge
        do_reset();
        check("rst_valid", 32'(rpt_valid), 32'd0);
        check("rst_idx", 32'(rpt_idx), 32'd0);
        check("rst_stamp", rpt_stamp, 32'd0);
        check("rst_sticky", 32'(sticky), 32'd0);
        check("rst_any_block", 32'(any_block), 32'd0);

        // Single held block: report after edge 17, then never again
        mon_block = 4'b0001;
        rpt_ready = 1'b1;
        repeat (16) tick();
        check("a_valid_e16", 32'(rpt_valid), 32'd0);
        tick();
        check("a_valid_e17", 32'(rpt_valid), 32'd1);
        check("a_idx", 32'(rpt_idx), 32'd0);
        tick();
        check("a_sticky", 32'(sticky), 32'b0001);
        seen = 0;
        repeat (40) begin
            tick();
            if (rpt_valid) seen++;
        end
        check("a_no_second", 32'(seen), 32'd0);

        // Round-robin order 1 then 3, pointer wraps to 0 (re-grant of 1 after clear)
        do_reset();
        for (int v = 0; v < 11; v++) begin
            mon_block = vecs[v].mb;
            clear     = vecs[v].clr;
            rpt_ready = vecs[v].rdy;
            repeat (vecs[v].n) tick();
            check($sformatf("vec%0d_valid", v), 32'(rpt_valid), 32'(vecs[v].exp_valid));
            if (vecs[v].exp_valid)
                check($sformatf("vec%0d_idx", v), 32'(rpt_idx), 32'(vecs[v].exp_idx));
            check($sformatf("vec%0d_sticky", v), 32'(sticky), 32'(vecs[v].exp_sticky));
        end
        clear = 1'b0;

        // 15-cycle glitch does not report and restarts the counter
        do_reset();
        rpt_ready = 1'b1;
        mon_block = 4'b0100;
        repeat (15) tick();
        mon_block = 4'b0000;
        repeat (3) tick();
        check("b_no_report", 32'(rpt_valid), 32'd0);
        check("b_sticky", 32'(sticky), 32'd0);
        mon_block = 4'b0100;
        repeat (16) tick();
        check("b_restart_e16", 32'(rpt_valid), 32'd0);
        tick();
        check("b_restart_e17", 32'(rpt_valid), 32'd1);
        check("b_restart_idx", 32'(rpt_idx), 32'd2);

        // Back-pressure: report payload held while the block drops
        do_reset();
        mon_block = 4'b0001;
        rpt_ready = 1'b0;
        repeat (17) tick();
        held_stamp = STAMP_EN ? 32'd16 : 32'd0;
        check("c_valid", 32'(rpt_valid), 32'd1);
        check("c_stamp", rpt_stamp, held_stamp);
        mon_block = 4'b0000;
        repeat (10) begin
            tick();
            check("c_hold_valid", 32'(rpt_valid), 32'd1);
            check("c_hold_idx", 32'(rpt_idx), 32'd0);
            check("c_hold_stamp", rpt_stamp, held_stamp);
        end
        rpt_ready = 1'b1;
        tick();
        check("c_done_valid", 32'(rpt_valid), 32'd0);
        check("c_done_sticky", 32'(sticky), 32'b0001);

        // clear in the handshake cycle: sticky cleared, re-report after a new window
        do_reset();
        mon_block = 4'b0001;
        rpt_ready = 1'b1;
        repeat (17) tick();
        check("d_valid", 32'(rpt_valid), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("d_hs_valid", 32'(rpt_valid), 32'd0);
        check("d_sticky_clr", 32'(sticky), 32'd0);
        repeat (16) tick();
        check("d_rearm_early", 32'(rpt_valid), 32'd0);
        tick();
        check("d_rearm_valid", 32'(rpt_valid), 32'd1);
        check("d_rearm_idx", 32'(rpt_idx), 32'd0);
        tick();
        check("d_rearm_sticky", 32'(sticky), 32'b0001);

        // Asynchronous reset in the middle of a report
        do_reset();
        mon_block = 4'b0001;
        rpt_ready = 1'b1;
        repeat (18) tick();
        mon_block = 4'b0100;
        rpt_ready = 1'b0;
        repeat (17) tick();
        check("e_valid_pre", 32'(rpt_valid), 32'd1);
        check("e_idx_pre", 32'(rpt_idx), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("e_valid_async", 32'(rpt_valid), 32'd0);
        check("e_idx_async", 32'(rpt_idx), 32'd0);
        check("e_stamp_async", rpt_stamp, 32'd0);
        check("e_sticky_async", 32'(sticky), 32'd0);
        check("e_any_async", 32'(any_block), 32'd0);
        model_reset();
        mon_block = 4'b0000;
        @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (3) tick();

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 31) == 0)
                    mon_block[b] = ~mon_block[b];
            end
            clear     = ($urandom_range(0, 149) == 0);
            rpt_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
